// File: rtl/mips_control_pipeline_if.sv
// Bus between the decode stage and the control-word pipeline: incoming instruction,
// hold/flush controls, and the per-stage state and hazard/forward selects returned.
interface mips_control_pipeline_if #(
    parameter int CONTROL_W = 32,
    parameter int STAGES    = 3,
    parameter int REG_W     = 5
);
    logic                        in_valid;
    logic [CONTROL_W-1:0]        in_control;
    logic [REG_W-1:0]            in_dest;
    logic                        in_writes;
    logic                        in_load;
    logic [REG_W-1:0]            src_a;
    logic [REG_W-1:0]            src_b;
    logic                        hold;
    logic                        flush;
    logic                        in_ready;
    logic                        hazard_stall;
    logic [STAGES-1:0]           forward_a;
    logic [STAGES-1:0]           forward_b;
    logic [STAGES-1:0]           stage_valid;
    logic [STAGES*CONTROL_W-1:0] stage_control;
    logic [STAGES*REG_W-1:0]     stage_dest;
    logic [STAGES-1:0]           stage_writes;
    logic [STAGES-1:0]           stage_load;

    modport master (
        output in_valid, in_control, in_dest, in_writes, in_load, src_a, src_b, hold, flush,
        input  in_ready, hazard_stall, forward_a, forward_b,
        input  stage_valid, stage_control, stage_dest, stage_writes, stage_load
    );

    modport slave (
        input  in_valid, in_control, in_dest, in_writes, in_load, src_a, src_b, hold, flush,
        output in_ready, hazard_stall, forward_a, forward_b,
        output stage_valid, stage_control, stage_dest, stage_writes, stage_load
    );
endinterface

// File: rtl/mips_control_pipeline.sv
// Carries decoded control words through STAGES valid-tagged stages with hold/flush,
// and derives load-use stall plus youngest-first forwarding selects.
module mips_control_pipeline #(
    parameter int CONTROL_W   = 32,
    parameter int STAGES      = 3,
    parameter int REG_W       = 5,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic clock,
    input  logic reset,
    mips_control_pipeline_if.slave bus
);
    logic [STAGES-1:0]    valid_reg, valid_next;
    logic [STAGES-1:0]    writes_reg, writes_next;
    logic [STAGES-1:0]    load_reg, load_next;
    logic [CONTROL_W-1:0] control_reg [STAGES];
    logic [CONTROL_W-1:0] control_next [STAGES];
    logic [REG_W-1:0]     dest_reg [STAGES];
    logic [REG_W-1:0]     dest_next [STAGES];

    logic                 hazard;
    logic                 ready;
    logic [STAGES-1:0]    fwd_a, fwd_b;

    // Only a load sitting in EX can create a load-use hazard; later stages forward.
    always_comb begin
        hazard = bus.in_valid & valid_reg[0] & load_reg[0] & (dest_reg[0] != '0) &
                 ((bus.src_a == dest_reg[0]) | (bus.src_b == dest_reg[0]));
        ready  = bus.in_valid & ~hazard & ~bus.hold & ~bus.flush;
    end

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (valid_reg[i] && writes_reg[i] && !(i == 0 && load_reg[0])) begin
                if (bus.src_a != '0 && dest_reg[i] == bus.src_a) begin
                    fwd_a    = '0;
                    fwd_a[i] = 1'b1;
                end
                if (bus.src_b != '0 && dest_reg[i] == bus.src_b) begin
                    fwd_b    = '0;
                    fwd_b[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        valid_next   = valid_reg;
        writes_next  = writes_reg;
        load_next    = load_reg;
        control_next = control_reg;
        dest_next    = dest_reg;
        if (!bus.hold) begin
            // ready already excludes flush, so stage 0 is a bubble whenever flushing.
            valid_next[0]   = ready;
            control_next[0] = bus.in_control;
            dest_next[0]    = bus.in_dest;
            writes_next[0]  = bus.in_writes;
            load_next[0]    = bus.in_load;
            for (int i = 1; i < STAGES; i++) begin
                valid_next[i]   = valid_reg[i-1] & ~(bus.flush & (i < FLUSH_DEPTH));
                control_next[i] = control_reg[i-1];
                dest_next[i]    = dest_reg[i-1];
                writes_next[i]  = writes_reg[i-1];
                load_next[i]    = load_reg[i-1];
            end
        end else if (bus.flush) begin
            for (int i = 0; i < STAGES; i++) begin
                if (i < FLUSH_DEPTH) begin
                    valid_next[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg  <= '0;
            writes_reg <= '0;
            load_reg   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                control_reg[i] <= '0;
                dest_reg[i]    <= '0;
            end
        end else begin
            valid_reg    <= valid_next;
            writes_reg   <= writes_next;
            load_reg     <= load_next;
            control_reg  <= control_next;
            dest_reg     <= dest_next;
        end
    end

    assign bus.in_ready     = ready;
    assign bus.hazard_stall = hazard;
    assign bus.forward_a    = fwd_a;
    assign bus.forward_b    = fwd_b;
    assign bus.stage_valid  = valid_reg;
    assign bus.stage_writes = writes_reg;
    assign bus.stage_load   = load_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_pack
            assign bus.stage_control[gi*CONTROL_W +: CONTROL_W] = control_reg[gi];
            assign bus.stage_dest[gi*REG_W +: REG_W]            = dest_reg[gi];
        end
    endgenerate
endmodule

// File: tb/tb_mips_control_pipeline.sv
// Scenario bench for mips_control_pipeline (3 stages, flush depth 2) with a
// queue-based scoreboard for the streaming path.
module tb_mips_control_pipeline;
    localparam int CW = 32;
    localparam int ST = 3;
    localparam int RW = 5;
    localparam int FD = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [CW-1:0] sb_q [$];

    always #5 clk = ~clk;

    mips_control_pipeline_if #(.CONTROL_W(CW), .STAGES(ST), .REG_W(RW)) bus ();

    mips_control_pipeline #(
        .CONTROL_W(CW), .STAGES(ST), .REG_W(RW), .FLUSH_DEPTH(FD)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [RW-1:0] d,
                         input logic w, input logic l, input logic [RW-1:0] sa,
                         input logic [RW-1:0] sb);
        bus.in_valid   = v;
        bus.in_control = c;
        bus.in_dest    = d;
        bus.in_writes  = w;
        bus.in_load    = l;
        bus.src_a      = sa;
        bus.src_b      = sb;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b1, 32'hdead, 5'd4, 1'b1, 1'b0, 5'd1, 5'd2);
        #1;
        n_cmp++; if (bus.stage_valid !== 3'b000) begin n_fail++; $display("FAIL reset_valid got=%b exp=000", bus.stage_valid); end
        n_cmp++; if (bus.stage_control !== '0) begin n_fail++; $display("FAIL reset_control got=%h exp=0", bus.stage_control); end
        n_cmp++; if (bus.stage_dest !== '0 || bus.stage_writes !== '0 || bus.stage_load !== '0) begin n_fail++; $display("FAIL reset_fields got=%h/%b/%b exp=0", bus.stage_dest, bus.stage_writes, bus.stage_load); end
        n_cmp++; if (bus.forward_a !== '0 || bus.forward_b !== '0 || bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL reset_fwd got=%b/%b/%b exp=0", bus.forward_a, bus.forward_b, bus.hazard_stall); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
        bus.hold = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_hold got=%b exp=0", bus.in_ready); end
        bus.hold = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_stream();
        logic [CW-1:0] exp_c;
        int seen = 0;
        do_reset();
        sb_q.delete();
        for (int k = 0; k < 9; k++) begin
            if (k < 6) begin
                drive(1'b1, CW'(32'h11 + k), RW'(k + 10), 1'b1, 1'b0, '0, '0);
                #1;
                n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready k=%0d got=%b exp=1", k, bus.in_ready); end
                sb_q.push_back(CW'(32'h11 + k));
            end else begin
                drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
            end
            step();
            if (k >= 2 && k < 6) begin
                n_cmp++; if (bus.stage_valid !== 3'b111) begin n_fail++; $display("FAIL stream_full k=%0d got=%b exp=111", k, bus.stage_valid); end
            end
            if (bus.stage_valid[2]) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra got=%h exp=none", bus.stage_control[2*CW +: CW]);
                end else begin
                    exp_c = sb_q.pop_front();
                    seen++;
                    if (bus.stage_control[2*CW +: CW] !== exp_c) begin n_fail++; $display("FAIL stream_s2 got=%h exp=%h", bus.stage_control[2*CW +: CW], exp_c); end
                    else $display("stream: stage2 control %h", exp_c);
                end
            end
        end
        n_cmp++; if (seen != 6 || sb_q.size() != 0) begin n_fail++; $display("FAIL stream_count got=%0d exp=6 left=%0d", seen, sb_q.size()); end
    endtask

    task automatic test_hazard();
        do_reset();
        drive(1'b1, 32'h41, 5'd5, 1'b1, 1'b1, '0, '0);
        step();
        drive(1'b1, 32'h42, 5'd7, 1'b1, 1'b0, 5'd5, 5'd1);
        #1;
        n_cmp++; if (bus.hazard_stall !== 1'b1) begin n_fail++; $display("FAIL hazard_stall got=%b exp=1", bus.hazard_stall); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hazard_ready got=%b exp=0", bus.in_ready); end
        step();
        n_cmp++; if (bus.stage_valid !== 3'b010) begin n_fail++; $display("FAIL hazard_bubble got=%b exp=010", bus.stage_valid); end
        n_cmp++; if (bus.hazard_stall !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hazard_retry got=%b/%b exp=0/1", bus.hazard_stall, bus.in_ready); end
        n_cmp++; if (bus.forward_a !== 3'b010) begin n_fail++; $display("FAIL hazard_fwd_a got=%b exp=010", bus.forward_a); end
        $display("test_hazard done");
    endtask

    task automatic test_forward();
        do_reset();
        drive(1'b1, 32'h51, 5'd3, 1'b1, 1'b0, '0, '0); step();
        drive(1'b1, 32'h52, 5'd9, 1'b1, 1'b0, '0, '0); step();
        drive(1'b1, 32'h53, 5'd3, 1'b1, 1'b0, '0, '0); step();
        drive(1'b1, 32'h54, 5'd8, 1'b0, 1'b0, 5'd9, 5'd3);
        #1;
        n_cmp++; if (bus.forward_b !== 3'b001) begin n_fail++; $display("FAIL fwd_youngest got=%b exp=001", bus.forward_b); end
        n_cmp++; if (bus.forward_a !== 3'b010) begin n_fail++; $display("FAIL fwd_mid got=%b exp=010", bus.forward_a); end
        drive(1'b1, 32'h55, 5'd8, 1'b0, 1'b0, 5'd12, 5'd3);
        #1;
        n_cmp++; if (bus.forward_a !== 3'b000) begin n_fail++; $display("FAIL fwd_none got=%b exp=000", bus.forward_a); end
        do_reset();
        drive(1'b1, 32'h56, 5'd0, 1'b1, 1'b0, '0, '0); step();
        drive(1'b1, 32'h57, 5'd0, 1'b1, 1'b1, '0, '0); step();
        drive(1'b1, 32'h58, 5'd6, 1'b1, 1'b0, 5'd0, 5'd0);
        #1;
        n_cmp++; if (bus.forward_b !== 3'b000 || bus.forward_a !== 3'b000) begin n_fail++; $display("FAIL fwd_r0 got=%b/%b exp=000", bus.forward_a, bus.forward_b); end
        n_cmp++; if (bus.hazard_stall !== 1'b0) begin n_fail++; $display("FAIL hazard_r0 got=%b exp=0", bus.hazard_stall); end
        $display("test_forward done");
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, CW'(32'h21 + k), 5'd1, 1'b0, 1'b0, '0, '0);
            step();
        end
        drive(1'b1, 32'h24, 5'd1, 1'b0, 1'b0, '0, '0);
        bus.flush = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%b exp=0", bus.in_ready); end
        step();
        bus.flush = 1'b0;
        n_cmp++; if (bus.stage_valid !== 3'b100) begin n_fail++; $display("FAIL flush_valid got=%b exp=100", bus.stage_valid); end
        n_cmp++; if (bus.stage_control[2*CW +: CW] !== 32'h22) begin n_fail++; $display("FAIL flush_s2 got=%h exp=22", bus.stage_control[2*CW +: CW]); end
        $display("test_flush done");
    endtask

    task automatic test_hold();
        logic [ST*CW-1:0] exp_ctl;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, CW'(32'h31 + k), RW'(k + 1), 1'b1, 1'b0, '0, '0);
            step();
        end
        exp_ctl = {32'h31, 32'h32, 32'h33};
        drive(1'b1, 32'h99, 5'd2, 1'b1, 1'b0, '0, '0);
        bus.hold = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready got=%b exp=0", bus.in_ready); end
        for (int c = 0; c < 4; c++) begin
            step();
            n_cmp++; if (bus.stage_valid !== 3'b111 || bus.stage_control !== exp_ctl) begin n_fail++; $display("FAIL hold_keep c=%0d got=%b/%h exp=111/%h", c, bus.stage_valid, bus.stage_control, exp_ctl); end
        end
        n_cmp++; if (bus.stage_dest !== {5'd1, 5'd2, 5'd3}) begin n_fail++; $display("FAIL hold_dest got=%h exp=%h", bus.stage_dest, {5'd1, 5'd2, 5'd3}); end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        n_cmp++; if (bus.stage_valid !== 3'b100) begin n_fail++; $display("FAIL hold_flush got=%b exp=100", bus.stage_valid); end
        n_cmp++; if (bus.stage_control !== exp_ctl) begin n_fail++; $display("FAIL hold_flush_ctl got=%h exp=%h", bus.stage_control, exp_ctl); end
        bus.hold = 1'b0;
        $display("test_hold done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, CW'(32'h61 + k), 5'd4, 1'b1, 1'b1, '0, '0);
            step();
        end
        bus.hold = 1'b1;
        bus.flush = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.hold = 1'b0;
        bus.flush = 1'b0;
        n_cmp++; if (bus.stage_valid !== 3'b000 || bus.stage_control !== '0) begin n_fail++; $display("FAIL rst_mid got=%b/%h exp=000/0", bus.stage_valid, bus.stage_control); end
        drive(1'b1, 32'h55, 5'd6, 1'b1, 1'b0, '0, '0);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        n_cmp++; if (bus.stage_valid !== 3'b001 || bus.stage_control[CW-1:0] !== 32'h55) begin n_fail++; $display("FAIL rst_first got=%b/%h exp=001/55", bus.stage_valid, bus.stage_control[CW-1:0]); end
        $display("test_reset_mid done");
    endtask

    initial begin
        rst = 1'b1;
        bus.hold = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        step();
        test_reset();
        test_stream();
        test_hazard();
        test_forward();
        test_flush();
        test_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
